vga_sync_rx: RTL and testbench
==============================

Name: vga_sync_rx

Overview:
- Receive-side counterpart of the display timing generator: consumes hSync/vSync/bright as they leave the VGA timing generator, recovers pixel coordinates and checks 640x480@60 timing.
- Sits beside the display path as a self-check monitor; its lock and error outputs feed the SSDs/LEDs, and its recovered coordinates can feed a capture or overlay block.
- Runs on the 100 MHz board clock and samples once per pixel-clock enable.

Parameters:
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hSync low width in pixels
- H_BP, 48, back porch after hSync
- H_ACT, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vSync low width in lines
- V_BP, 33, back porch lines
- V_ACT, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames needed to lock (1..15)

Ports:
- Clk  in  1  100 MHz clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  one-Clk pixel strobe (every 4th Clk)
- hSync  in  1  active-low horizontal sync, same clock domain
- vSync  in  1  active-low vertical sync
- bright  in  1  active-video flag from the timing generator
- hCount_rx  out  10  recovered pixel index since hSync fall
- vCount_rx  out  10  recovered line index since vSync fall
- x  out  10  active-area column (0..639); valid only when pix_valid=1
- y  out  10  active-area row (0..479)
- pix_valid  out  1  recovered active region and locked
- locked  out  1  timing locked
- h_err  out  1  one-Clk pulse on a bad line length
- v_err  out  1  one-Clk pulse on a bad frame length or bright mismatch
- frame_cnt  out  8  frames completed while locked (wraps)

Behaviour:
- All state advances only on Clk edges with pix_en=1. There is no synchronizer, because the inputs share Clk.
- Reset (Reset_n=0, asynchronous): every counter and output is 0, FSM=SEARCH, hs_prev=vs_prev=1.
- Line start: pix_en sample with hSync=0 while hs_prev=1.
  - hCount_rx <= 0. Otherwise hCount_rx increments, saturating at 1023.
  - Measured line length is hCount_rx+1 at the line start.
- Frame start: a line start where vSync=0 and vs_prev_line=1. vs_prev_line is vSync sampled at the previous line start.
  - vCount_rx <= 0. Otherwise vCount_rx increments at each line start, saturating at 1023.
- Line-length check:
  - At each line start after the first, length != H_TOTAL flags a bad line.
  - In LOCKED this pulses h_err the next Clk.
- Frame-length check: at a frame start, vCount_rx+1 != V_TOTAL flags a bad frame.
- Active window:
  - act = hCount_rx in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and vCount_rx in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1].
  - x = hCount_rx-(H_SYNC+H_BP) and y = vCount_rx-(V_SYNC+V_BP) when act, else 0.
  - pix_valid = act & locked, registered.
- Bright check: in LOCKED, bright != act on any pix_en sample pulses v_err. The check is masked during the first line after a frame start.
- FSM:
  - SEARCH: wait for a frame start -> ACQUIRE, good=0.
  - ACQUIRE:
    - Any bad line -> SEARCH.
    - Frame start with a good frame -> good++; when good reaches LOCK_FRAMES -> LOCKED, locked=1.
    - Frame start with a bad frame -> good=0 and stay in ACQUIRE.
  - LOCKED:
    - Bad line, bad frame or bright mismatch -> pulse the matching err, then SEARCH with locked=0 the next Clk. frame_cnt holds.
    - A good frame start increments frame_cnt, wrapping at 255.
- Simultaneous bad line and bad frame on the same sample: both h_err and v_err pulse.
- Stuck sync: a saturated counter (1023) counts as a bad line or bad frame at the next start. Without a next start, LOCKED is left as soon as hCount_rx reaches 1023 (h_err pulses).
- Reset mid-frame: immediate return to SEARCH. Relock needs a full frame start plus LOCK_FRAMES good frames.

Decomposition:
- Shared package vga_timing_pkg:
  - the H_*/V_* constants, shared with the display timing generator
  - FSM state encoding {SEARCH, ACQUIRE, LOCKED}
- One natural sub-module, sync_edge_cnt: falling-edge detect plus saturating 10-bit counter. It is instantiated twice, once for horizontal (advance=pix_en) and once for vertical (advance=line start).

Test Plan:
- Drive the nominal 800x525 timing with pix_en every 4 Clk for 3 frames -> locked=1 on the frame start ending frame 2, no err pulses, frame_cnt=1 after frame 3.
- Locked, first active pixel (hCount_rx=144, vCount_rx=35) -> x=0, y=0, pix_valid=1; hCount_rx=783, vCount_rx=514 -> x=639, y=479; hCount_rx=784 -> pix_valid=0.
- Locked, shorten one line to 799 pixels -> h_err one-Clk pulse at that line start, locked=0 next Clk, relock after 2 further good frames.
- Locked, frame of 524 lines -> v_err pulse at the next frame start, FSM=SEARCH, frame_cnt unchanged.
- Locked, force bright=0 at hCount_rx=200 on line 100 -> v_err pulse, locked drops.
- Hold hSync=1 for 1100 pixels while locked -> h_err pulse when hCount_rx reaches 1023, locked=0. Assert Reset_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared with the display timing generator, plus
// the receive-side monitor state encoding.
package vga_timing_pkg;
  localparam int H_TOTAL = 800;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_ACT   = 640;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_ACT   = 480;

  localparam int              CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} rx_state_e;

  function automatic logic in_win(input logic [CNT_W-1:0] v, lo, hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/sync_edge_cnt.sv
// Falling-edge detector on an active-low sync plus a saturating position
// counter that restarts at every detected edge.
module sync_edge_cnt
  import vga_timing_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             sig_i,
  output logic             start_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o
);
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    start_o = adv_i & ~sig_i & prev_q;
    cnt_d   = cnt_q;
    if (start_o)                          cnt_d = '0;
    else if (adv_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      if (adv_i) prev_q <= sig_i;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync monitor: recovers pixel/line position from hSync/vSync, checks line
// and frame lengths plus the bright flag, and locks after good frames.
module vga_sync_rx #(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int H_ACT       = vga_timing_pkg::H_ACT,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int V_ACT       = vga_timing_pkg::V_ACT,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_en,
  input  logic       hSync,
  input  logic       vSync,
  input  logic       bright,
  output logic [9:0] hCount_rx,
  output logic [9:0] vCount_rx,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_valid,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] frame_cnt
);
  import vga_timing_pkg::*;

  localparam logic [9:0]  HOFF  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HEND  = 10'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  VOFF  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VEND  = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] H_LEN = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic       line_start, frame_start;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       act_d, bad_line, bad_frame, bright_bad;

  rx_state_e  state_q;
  logic [3:0] good_q;
  logic [7:0] frame_cnt_q;
  logic       locked_q, drop_q, seen_q, h_err_q, v_err_q;
  logic [9:0] x_q, y_q;
  logic       pv_q;

  sync_edge_cnt u_hcnt (
    .clk_i(Clk), .rst_ni(Reset_n), .adv_i(pix_en), .sig_i(hSync),
    .start_o(line_start), .cnt_o(hcnt_q), .cnt_d_o(hcnt_d)
  );

  sync_edge_cnt u_vcnt (
    .clk_i(Clk), .rst_ni(Reset_n), .adv_i(line_start), .sig_i(vSync),
    .start_o(frame_start), .cnt_o(vcnt_q), .cnt_d_o(vcnt_d)
  );

  // The sample being taken lands at position cnt_d, so all window and bright
  // decisions use the next-state counts.
  always_comb begin
    act_d      = in_win(hcnt_d, HOFF, HEND) && in_win(vcnt_d, VOFF, VEND);
    bad_line   = (line_start && seen_q && (({1'b0, hcnt_q} + 11'd1) != H_LEN)) ||
                 (pix_en && (hcnt_d == CNT_MAX));
    bad_frame  = frame_start && (({1'b0, vcnt_q} + 11'd1) != V_LEN);
    bright_bad = pix_en && (bright != act_d) && (vcnt_d != '0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      frame_cnt_q <= '0;
      locked_q    <= 1'b0;
      drop_q      <= 1'b0;
      seen_q      <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
    end else begin
      h_err_q <= 1'b0;
      v_err_q <= 1'b0;
      drop_q  <= 1'b0;
      if (line_start) seen_q <= 1'b1;
      // Error pulses first, lock is released on the following Clk.
      if (drop_q) begin
        state_q  <= SEARCH;
        locked_q <= 1'b0;
        good_q   <= '0;
      end else if (pix_en) begin
        case (state_q)
          SEARCH: if (frame_start) begin
            state_q <= ACQUIRE;
            good_q  <= '0;
          end
          ACQUIRE: begin
            if (bad_line) state_q <= SEARCH;
            else if (frame_start) begin
              if (bad_frame) good_q <= '0;
              else if (good_q + 4'd1 == LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else good_q <= good_q + 4'd1;
            end
          end
          LOCKED: begin
            if (bad_line || bad_frame || bright_bad) begin
              h_err_q <= bad_line;
              v_err_q <= bad_frame || bright_bad;
              drop_q  <= 1'b1;
            end else if (frame_start) frame_cnt_q <= frame_cnt_q + 8'd1;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      pv_q <= 1'b0;
    end else begin
      x_q  <= act_d ? hcnt_d - HOFF : '0;
      y_q  <= act_d ? vcnt_d - VOFF : '0;
      pv_q <= act_d && locked_q && !drop_q;
    end
  end

  assign hCount_rx = hcnt_q;
  assign vCount_rx = vcnt_q;
  assign x         = x_q;
  assign y         = y_q;
  assign pix_valid = pv_q;
  assign locked    = locked_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a scaled-down 20x10 timing so that
// many frames fit in a short run; pix_en fires every 4th Clk.
`timescale 1ns/1ps
module tb_vga_sync_rx;
  localparam int TH = 20, TS = 2, TB = 3, TA = 12;
  localparam int VT = 10, VS = 1, VB = 2, VA = 5;
  localparam int HO = TS + TB, VO = VS + VB;

  logic       Clk, Reset_n, pix_en, hSync, vSync, bright;
  logic [9:0] hCount_rx, vCount_rx, x, y;
  logic       pix_valid, locked, h_err, v_err;
  logic [7:0] frame_cnt;

  vga_sync_rx #(
    .H_TOTAL(TH), .H_SYNC(TS), .H_BP(TB), .H_ACT(TA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .LOCK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .bright(bright), .hCount_rx(hCount_rx), .vCount_rx(vCount_rx), .x(x), .y(y),
    .pix_valid(pix_valid), .locked(locked), .h_err(h_err), .v_err(v_err),
    .frame_cnt(frame_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { int h; int v; int ex; int ey; int epv; } vec_t;
  vec_t tab[7];

  int n_cmp = 0, n_bad = 0;
  int herr_cyc = 0, verr_cyc = 0, herr_hcnt = -1;
  logic ps_herr, ps_verr, ps_locked, nx_herr, nx_verr, nx_locked;

  always @(negedge Clk) begin
    if (h_err) begin herr_cyc++; herr_hcnt = int'(hCount_rx); end
    if (v_err) verr_cyc++;
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".hCount"}, int'(hCount_rx), 0);
    chk({tag, ".vCount"}, int'(vCount_rx), 0);
    chk({tag, ".x"}, int'(x), 0);
    chk({tag, ".y"}, int'(y), 0);
    chk({tag, ".pix_valid"}, int'(pix_valid), 0);
    chk({tag, ".locked"}, int'(locked), 0);
    chk({tag, ".h_err"}, int'(h_err), 0);
    chk({tag, ".v_err"}, int'(v_err), 0);
    chk({tag, ".frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // One pixel: strobe, then record outputs just after the sample edge and
  // one Clk later.
  task automatic send_pix(input logic hs, input logic vs, input logic br);
    pix_en = 1'b1; hSync = hs; vSync = vs; bright = br;
    @(posedge Clk); #1;
    ps_herr = h_err; ps_verr = v_err; ps_locked = locked;
    pix_en = 1'b0;
    @(posedge Clk); #1;
    nx_herr = h_err; nx_verr = v_err; nx_locked = locked;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic tab_check(input int h, input int v);
    for (int i = 0; i < 7; i++)
      if (tab[i].h == h && tab[i].v == v) begin
        chk($sformatf("hCount@%0d,%0d", h, v), int'(hCount_rx), h);
        chk($sformatf("vCount@%0d,%0d", h, v), int'(vCount_rx), v);
        chk($sformatf("x@%0d,%0d", h, v), int'(x), tab[i].ex);
        chk($sformatf("y@%0d,%0d", h, v), int'(y), tab[i].ey);
        chk($sformatf("pix_valid@%0d,%0d", h, v), int'(pix_valid), tab[i].epv);
      end
  endtask

  task automatic gen_line(input int v, input int h0, input int h1, input int kill_h,
                          input bit chk_en);
    logic br;
    for (int h = h0; h < h1; h++) begin
      br = (h >= HO) && (h < HO + TA) && (v >= VO) && (v < VO + VA);
      if (h == kill_h) br = ~br;
      send_pix(h >= TS, v >= VS, br);
      if (chk_en) tab_check(h, v);
    end
  endtask

  task automatic gen_frame(input int nlines, input int kill_v, input int kill_h,
                           input bit chk_en);
    for (int v = 0; v < nlines; v++)
      gen_line(v, 0, TH, (v == kill_v) ? kill_h : -1, chk_en);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{HO,          VO,          0,      0,      1};
    tab[1] = '{HO + TA - 1, VO + VA - 1, TA - 1, VA - 1, 1};
    tab[2] = '{HO + TA,     VO + VA - 1, 0,      0,      0};
    tab[3] = '{HO - 1,      VO,          0,      0,      0};
    tab[4] = '{10,          5,           5,      2,      1};
    tab[5] = '{10,          VO + VA,     0,      0,      0};
    tab[6] = '{10,          VO - 1,      0,      0,      0};

    Reset_n = 1'b0; pix_en = 1'b0; hSync = 1'b1; vSync = 1'b1; bright = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset");
    Reset_n = 1'b1;

    // Acquire and lock on nominal timing.
    gen_frame(VT, -1, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("lock.before_f3", int'(locked), 0);
    gen_frame(VT, -1, -1, 1'b1);
    chk("lock.after_f3", int'(locked), 1);
    chk("lock.fc_f3", int'(frame_cnt), 0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("lock.fc_f4", int'(frame_cnt), 1);
    chk("lock.herr_none", herr_cyc, 0);
    chk("lock.verr_none", verr_cyc, 0);

    // Short line: line 4 of 19 pixels.
    for (int v = 0; v < 4; v++) gen_line(v, 0, TH, -1, 1'b0);
    gen_line(4, 0, TH - 1, -1, 1'b0);
    send_pix(1'b0, 1'b1, 1'b0);
    chk("short.h_err", int'(ps_herr), 1);
    chk("short.v_err", int'(ps_verr), 0);
    chk("short.locked_at_err", int'(ps_locked), 1);
    chk("short.h_err_next", int'(nx_herr), 0);
    chk("short.locked_next", int'(nx_locked), 0);
    gen_line(5, 1, TH, -1, 1'b0);
    for (int v = 6; v < VT; v++) gen_line(v, 0, TH, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("short.relock_early", int'(locked), 0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("short.relock", int'(locked), 1);
    chk("short.fc", int'(frame_cnt), 2);

    // Frame of VT-1 lines.
    gen_frame(VT - 1, -1, -1, 1'b0);
    chk("frame.fc_before", int'(frame_cnt), 3);
    send_pix(1'b0, 1'b0, 1'b0);
    chk("frame.v_err", int'(ps_verr), 1);
    chk("frame.h_err", int'(ps_herr), 0);
    chk("frame.v_err_next", int'(nx_verr), 0);
    chk("frame.locked_next", int'(nx_locked), 0);
    chk("frame.fc_hold", int'(frame_cnt), 3);
    gen_line(0, 1, TH, -1, 1'b0);
    for (int v = 1; v < VT; v++) gen_line(v, 0, TH, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("frame.relock_early", int'(locked), 0);
    // Relock frame also carries a bright glitch in line 0, which is masked.
    gen_frame(VT, 0, 8, 1'b0);
    chk("mask.locked", int'(locked), 1);
    chk("mask.verr_cnt", verr_cyc, 1);

    // Bright glitch inside the active area.
    for (int v = 0; v < 5; v++) gen_line(v, 0, TH, -1, 1'b0);
    gen_line(5, 0, 8, -1, 1'b0);
    send_pix(1'b1, 1'b1, 1'b0);
    chk("bright.v_err", int'(ps_verr), 1);
    chk("bright.h_err", int'(ps_herr), 0);
    chk("bright.locked_next", int'(nx_locked), 0);
    chk("bright.fc", int'(frame_cnt), 4);
    gen_line(5, 9, TH, -1, 1'b0);
    for (int v = 6; v < VT; v++) gen_line(v, 0, TH, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("stuck.locked_before", int'(locked), 1);

    // Stuck hSync for 1100 pixels.
    for (int i = 0; i < 1100; i++) send_pix(1'b1, 1'b1, 1'b0);
    chk("stuck.locked", int'(locked), 0);
    chk("stuck.hcnt_sat", int'(hCount_rx), 1023);
    chk("stuck.herr_at", herr_hcnt, 1023);
    chk("stuck.herr_cyc", herr_cyc, 2);
    chk("stuck.verr_cyc", verr_cyc, 2);

    // Asynchronous reset between clock edges.
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    gen_frame(VT, -1, -1, 1'b0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("rst.relock_early", int'(locked), 0);
    gen_frame(VT, -1, -1, 1'b0);
    chk("rst.relock", int'(locked), 1);
    chk("rst.fc", int'(frame_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
